// File: rtl/fixed128_pkg.sv
// Shared constants, lane index type and keep-mask helper for the 32-to-128 bit packer.
package fixed128_pkg;

   localparam int WORD_W     = 32;
   localparam int LANES      = 4;
   localparam int OUT_W      = WORD_W * LANES;
   localparam int BCNT_W_DEF = 16;
   localparam int LANE_W     = $clog2(LANES);

   typedef logic [LANE_W-1:0] lane_idx_t;

   // Contiguous mask with lanes 0..c set.
   function automatic logic [LANES-1:0] keep_mask(input lane_idx_t c);
      logic [LANES-1:0] m;
      m = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i <= int'(c)) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/fixed128_pack_if.sv
// Word-in / block-out stream bundle between the feeder and the packer.
interface fixed128_pack_if
   import fixed128_pkg::*;
#(
   parameter int BCNT_W = BCNT_W_DEF
);

   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [OUT_W-1:0]  out_data;
   logic [LANES-1:0]  out_keep;
   logic              out_valid;
   logic              out_ready;
   logic [BCNT_W-1:0] blk_cnt;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_keep, out_valid, blk_cnt
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_keep, out_valid, blk_cnt
   );

endinterface

// File: rtl/fixed128_pack.sv
// Packs 32-bit words into 128-bit blocks; in_last closes a short block with zero-padded lanes.
module fixed128_pack
   import fixed128_pkg::*;
#(
   parameter int BCNT_W = BCNT_W_DEF
) (
   input  logic          fixed128_pack_clk,
   input  logic          fixed128_pack_reset,
   input  logic          fixed128_pack_init,
   input  logic          fixed128_pack_in_disable,
   fixed128_pack_if.slave bus
);

   logic              clr_s;
   logic              accept_s;
   logic              closing_s;
   logic              pop_s;
   logic [OUT_W-1:0]  ins_s;

   lane_idx_t         lane_q,      lane_d;
   logic [OUT_W-1:0]  acc_q,       acc_d;
   logic [OUT_W-1:0]  out_data_q,  out_data_d;
   logic [LANES-1:0]  out_keep_q,  out_keep_d;
   logic              out_valid_q, out_valid_d;
   logic [BCNT_W-1:0] blk_cnt_q,   blk_cnt_d;

   assign clr_s        = fixed128_pack_reset | fixed128_pack_init;
   assign bus.in_ready = ~fixed128_pack_in_disable & ~clr_s & (~out_valid_q | bus.out_ready);
   assign accept_s     = bus.in_valid & bus.in_ready;
   assign closing_s    = accept_s & (bus.in_last | (lane_q == lane_idx_t'(LANES - 1)));
   assign pop_s        = out_valid_q & bus.out_ready;

   // Accumulator with the incoming word dropped into the current lane; higher lanes stay zero.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign ins_s[k*WORD_W +: WORD_W] = (lane_q == lane_idx_t'(k)) ? bus.in_data
                                                                      : acc_q[k*WORD_W +: WORD_W];
   end

   // Next-state for lane counter, accumulator, output register and block counter.
   always_comb begin
      lane_d      = lane_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_valid_d = out_valid_q;
      blk_cnt_d   = blk_cnt_q;

      if (closing_s) begin
         lane_d      = '0;
         acc_d       = '0;
         out_data_d  = ins_s;
         out_keep_d  = keep_mask(lane_q);
         out_valid_d = 1'b1;
      end else if (accept_s) begin
         lane_d = lane_q + lane_idx_t'(1);
         acc_d  = ins_s;
         if (pop_s) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
      end else if (pop_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      if (pop_s) begin
         blk_cnt_d = blk_cnt_q + BCNT_W'(1);
      end else begin
         blk_cnt_d = blk_cnt_q;
      end
   end

   // State register; clear discards any partial block and pending output.
   always_ff @(posedge fixed128_pack_clk) begin
      if (clr_s) begin
         lane_q      <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_valid_q <= 1'b0;
         blk_cnt_q   <= '0;
      end else begin
         lane_q      <= lane_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_valid_q <= out_valid_d;
         blk_cnt_q   <= blk_cnt_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_keep  = out_keep_q;
   assign bus.out_valid = out_valid_q;
   assign bus.blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_fixed128_pack.sv
// Scoreboard bench for fixed128_pack: expected blocks are queued on acceptance and checked on handoff.
module tb_fixed128_pack;
   import fixed128_pkg::*;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic [LANES-1:0] k;
   } blk_t;

   logic clk;
   logic reset;
   logic init;
   logic dis;

   fixed128_pack_if #(.BCNT_W(16)) bus ();

   fixed128_pack #(.BCNT_W(16)) dut (
      .fixed128_pack_clk        (clk),
      .fixed128_pack_reset      (reset),
      .fixed128_pack_init       (init),
      .fixed128_pack_in_disable (dis),
      .bus                      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   blk_t        sb[$];
   logic [31:0] m_acc[LANES];
   int          m_lane = 0;
   logic [15:0] blk_exp = 16'h0000;

   // One clock: check outputs at negedge, update model, check counter after the edge.
   task automatic step(output bit acc);
      bit   exp_ov, exp_ir, pop;
      blk_t b;
      acc = 1'b0;
      pop = 1'b0;
      @(negedge clk);
      exp_ov = (sb.size() != 0);
      checks++;
      if (bus.out_valid !== exp_ov) begin
         errors++;
         $display("FAIL out_valid got %b want %b at %0t", bus.out_valid, exp_ov, $time);
      end
      if (exp_ov) begin
         checks++;
         if (bus.out_data !== sb[0].d || bus.out_keep !== sb[0].k) begin
            errors++;
            $display("FAIL out_block got %h/%b want %h/%b at %0t",
                     bus.out_data, bus.out_keep, sb[0].d, sb[0].k, $time);
         end
         if (bus.out_ready) begin
            void'(sb.pop_front());
            pop = 1'b1;
         end
      end
      exp_ir = !dis && !reset && !init && (!exp_ov || bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_ir) begin
         errors++;
         $display("FAIL in_ready got %b want %b at %0t", bus.in_ready, exp_ir, $time);
      end
      if (reset || init) begin
         sb.delete();
         m_lane  = 0;
         blk_exp = 16'h0000;
      end else begin
         if (pop) blk_exp = blk_exp + 16'h0001;
         if (bus.in_valid && exp_ir) begin
            acc = 1'b1;
            m_acc[m_lane] = bus.in_data;
            if (bus.in_last || m_lane == LANES - 1) begin
               b.d = '0;
               for (int i = 0; i <= m_lane; i++) b.d[i*WORD_W +: WORD_W] = m_acc[i];
               b.k = LANES'((1 << (m_lane + 1)) - 1);
               sb.push_back(b);
               m_lane = 0;
            end else begin
               m_lane++;
            end
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.blk_cnt !== blk_exp) begin
         errors++;
         $display("FAIL blk_cnt got %h want %h at %0t", bus.blk_cnt, blk_exp, $time);
      end
   endtask

   task automatic send(input logic [31:0] w, input bit last, output int tries);
      bit a;
      bus.in_data  = w;
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      tries = 0;
      a = 1'b0;
      while (!a && tries < 50) begin
         step(a);
         tries++;
      end
      if (!a) begin
         errors++;
         $display("FAIL send_timeout word %h not accepted in %0d cycles", w, tries);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      bit a;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      for (int i = 0; i < n; i++) step(a);
   endtask

   task automatic test_reset();
      bit a;
      reset = 1'b1; init = 1'b0; dis = 1'b0;
      bus.in_data = 32'h0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      step(a);
      reset = 1'b0;
      checks++;
      if (bus.out_data !== 128'h0 || bus.out_keep !== 4'b0000 || bus.blk_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state got %h/%b/%h want zeros", bus.out_data, bus.out_keep, bus.blk_cnt);
      end
   endtask

   task automatic test_full_block();
      int t;
      send(32'h11111111, 1'b0, t);
      send(32'h22222222, 1'b0, t);
      send(32'h33333333, 1'b0, t);
      send(32'h44444444, 1'b0, t);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_keep !== 4'b1111 ||
          bus.out_data !== 128'h44444444_33333333_22222222_11111111) begin
         errors++;
         $display("FAIL full_block got %b %h/%b want 1 44444444333333332222222211111111/1111",
                  bus.out_valid, bus.out_data, bus.out_keep);
      end
      idle(1);
      checks++;
      if (bus.blk_cnt !== 16'd1) begin
         errors++;
         $display("FAIL full_block_cnt got %0d want 1", bus.blk_cnt);
      end
   endtask

   task automatic test_short_block();
      int t;
      send(32'h0000000A, 1'b0, t);
      send(32'h0000000B, 1'b1, t);
      checks++;
      if (bus.out_keep !== 4'b0011 || bus.out_data !== 128'h0000000B_0000000A) begin
         errors++;
         $display("FAIL short_block got %h/%b want 0000000b0000000a/0011", bus.out_data, bus.out_keep);
      end
      idle(1);
   endtask

   task automatic test_back_to_back();
      int t;
      logic [15:0] start;
      start = blk_exp;
      for (int i = 0; i < 8; i++) begin
         send(32'hB000_0000 + 32'(i), 1'b0, t);
         checks++;
         if (t != 1) begin
            errors++;
            $display("FAIL stream_ready word %0d took %0d cycles want 1", i, t);
         end
      end
      idle(2);
      checks++;
      if (bus.blk_cnt !== start + 16'd2) begin
         errors++;
         $display("FAIL stream_cnt got %0d want %0d", bus.blk_cnt, start + 16'd2);
      end
   endtask

   task automatic test_stall();
      int t;
      bit a;
      bit any;
      for (int i = 0; i < 4; i++) send(32'hC100_0000 + 32'(i), 1'b0, t);
      bus.out_ready = 1'b0;
      bus.in_data = 32'hC2FF_FFFF; bus.in_valid = 1'b1;
      any = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(a);
         any = any | a;
      end
      checks++;
      if (any) begin
         errors++;
         $display("FAIL stall_accept got accepted=1 want 0");
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(32'hC200_0000 + 32'(i), 1'b0, t);
      idle(2);
   endtask

   task automatic test_init();
      int t;
      bit a;
      send(32'hD0000001, 1'b0, t);
      send(32'hD0000002, 1'b0, t);
      init = 1'b1;
      step(a);
      init = 1'b0;
      checks++;
      if (bus.blk_cnt !== 16'h0000 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL init_clear got cnt %h valid %b want 0000 0", bus.blk_cnt, bus.out_valid);
      end
      for (int i = 0; i < 4; i++) send(32'hE000_0000 + 32'(i), 1'b0, t);
      idle(2);
   endtask

   task automatic test_disable_wrap();
      int t;
      bit a;
      bit any;
      send(32'h00000061, 1'b0, t);
      send(32'h00000062, 1'b0, t);
      dis = 1'b1;
      bus.in_data = 32'h0000006F; bus.in_valid = 1'b1;
      any = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(a);
         any = any | a;
      end
      checks++;
      if (any) begin
         errors++;
         $display("FAIL disable_accept got accepted=1 want 0");
      end
      dis = 1'b0;
      send(32'h00000063, 1'b0, t);
      send(32'h00000064, 1'b0, t);
      idle(2);
      for (int n = 0; n < 70000 && blk_exp != 16'hFFFF; n++) begin
         send(32'(n), 1'b1, t);
      end
      idle(2);
      checks++;
      if (bus.blk_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL cnt_wrap got %h want 0000", bus.blk_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_full_block();
      test_short_block();
      test_back_to_back();
      test_stall();
      test_init();
      test_disable_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
